// File: rtl/distributor.sv
// One-to-many stream distributor: steers each tagged upstream word into one of
// PORTS independent FIFOs, each draining to its own consumer under a per-port stall.
module distributor #(
    parameter int WIDTH      = 8,
    parameter int PORTS      = 8,
    parameter int DEST_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int AF_MARGIN  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DEST_WIDTH-1:0]   dest,
    input  logic [WIDTH-1:0]        d,
    output logic [0:PORTS-1]        full,
    output logic [0:PORTS-1]        almost_full,
    output logic [PORTS*WIDTH-1:0]  q,
    output logic [0:PORTS-1]        valid,
    input  logic [0:PORTS-1]        stall,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] AF_C    = (PW+1)'(AF_MARGIN);

    logic [WIDTH-1:0] mem    [PORTS][DEPTH];
    logic [PW-1:0]    wr_ptr [PORTS];
    logic [PW-1:0]    rd_ptr [PORTS];
    logic [PW:0]      count  [PORTS];
    logic [WIDTH-1:0] q_r    [PORTS];

    logic             dest_ok;
    logic             drop;
    logic [0:PORTS-1] wr_sel;
    logic [0:PORTS-1] pop;

    assign dest_ok = (32'(dest) < PORTS);

    // Flags decode registered counts only; a push to a full port is dropped
    // even if that port pops on the same edge.
    always_comb begin
        full        = '0;
        almost_full = '0;
        wr_sel      = '0;
        pop         = '0;
        drop        = push && !dest_ok;
        for (int unsigned i = 0; i < PORTS; i++) begin
            full[i]        = (count[i] == DEPTH_C);
            almost_full[i] = ((DEPTH_C - count[i]) <= AF_C);
            pop[i]         = (count[i] != '0) && !stall[i];
            if (push && dest_ok && (dest == DEST_WIDTH'(i))) begin
                if (full[i])
                    drop = 1'b1;
                else
                    wr_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (wr_sel[i])
                    mem[i][wr_ptr[i]] <= d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                q_r[i]    <= '0;
            end
            valid    <= '0;
            overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (wr_sel[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i]) begin
                    q_r[i]    <= mem[i][rd_ptr[i]];
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                valid[i] <= pop[i];
                count[i] <= count[i] + (PW+1)'(wr_sel[i]) - (PW+1)'(pop[i]);
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Port 0 occupies the most significant slice of q.
    for (genvar g = 0; g < PORTS; g++) begin : g_pack
        assign q[(PORTS-g)*WIDTH-1 -: WIDTH] = q_r[g];
    end

endmodule
